// File: rtl/invader_fleet_pkg.sv
// Shared constants and encodings for the invader fleet: formation geometry,
// screen bounds, and the fleet state / march direction enums.
package invader_fleet_pkg;

  localparam int unsigned INVADERS_H = 11;
  localparam int unsigned INVADERS_V = 5;
  localparam int unsigned N_INV      = INVADERS_H * INVADERS_V;
  localparam int unsigned OFFSET_H   = 32;
  localparam int unsigned OFFSET_V   = 32;
  localparam int unsigned INV_W      = 24;
  localparam int unsigned INV_H      = 16;

  localparam int unsigned STEP_X_DEF  = 4;
  localparam int unsigned STEP_Y_DEF  = 16;
  localparam int unsigned START_X_DEF = 80;
  localparam int unsigned START_Y_DEF = 64;
  localparam int unsigned X_MIN_DEF   = 8;
  localparam int unsigned X_MAX_DEF   = 631;
  localparam int unsigned Y_LIMIT_DEF = 400;

  typedef enum logic [1:0] {
    FLEET_IDLE,
    FLEET_RUN,
    FLEET_CLEARED,
    FLEET_LANDED
  } fleet_state_t;

  typedef enum logic {
    DIR_RIGHT,
    DIR_LEFT
  } fleet_dir_t;

endpackage

// File: rtl/invader_fleet_extent.sv
// Combinational extent of the alive mask: leftmost/rightmost occupied column,
// bottom occupied row, and whether anything is alive at all.
module fleet_extent
  import invader_fleet_pkg::*;
(
  input  logic [N_INV-1:0] invaders,
  output logic [3:0]       leftcol,
  output logic [3:0]       rightcol,
  output logic [2:0]       bottomrow,
  output logic             any_alive
);

  logic [INVADERS_H-1:0] col_occ;
  logic [INVADERS_V-1:0] row_occ;

  always_comb begin
    col_occ = '0;
    row_occ = '0;
    for (int unsigned r = 0; r < INVADERS_V; r++) begin
      for (int unsigned c = 0; c < INVADERS_H; c++) begin
        col_occ[c] = col_occ[c] | invaders[r*INVADERS_H + c];
        row_occ[r] = row_occ[r] | invaders[r*INVADERS_H + c];
      end
    end
  end

  // Later matches overwrite earlier ones, so scan direction picks the priority.
  always_comb begin
    leftcol   = '0;
    rightcol  = '0;
    bottomrow = '0;
    for (int unsigned c = INVADERS_H; c > 0; c--)
      if (col_occ[c-1]) leftcol = 4'(c - 1);
    for (int unsigned c = 0; c < INVADERS_H; c++)
      if (col_occ[c]) rightcol = 4'(c);
    for (int unsigned r = 0; r < INVADERS_V; r++)
      if (row_occ[r]) bottomrow = 3'(r);
  end

  assign any_alive = |col_occ;

endmodule

// File: rtl/invader_fleet.sv
// Invader formation state: per-frame march/drop, hit kills, speed-up as the
// fleet thins, and sticky cleared/landed flags for game control.
module invader_fleet
  import invader_fleet_pkg::*;
#(
  parameter int unsigned STEP_X  = STEP_X_DEF,
  parameter int unsigned STEP_Y  = STEP_Y_DEF,
  parameter int unsigned START_X = START_X_DEF,
  parameter int unsigned START_Y = START_Y_DEF,
  parameter int unsigned X_MIN   = X_MIN_DEF,
  parameter int unsigned X_MAX   = X_MAX_DEF,
  parameter int unsigned Y_LIMIT = Y_LIMIT_DEF
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             frame,
  input  logic             start,
  input  logic             hit,
  input  logic [2:0]       hit_row,
  input  logic [3:0]       hit_col,
  output logic [N_INV-1:0] invaders,
  output logic [9:0]       invaders_x,
  output logic [9:0]       invaders_y,
  output logic [5:0]       alive_count,
  output logic             cleared,
  output logic             landed
);

  fleet_state_t     state_q, state_nx;
  fleet_dir_t       dir_q, dir_nx;
  logic [N_INV-1:0] mask_q, mask_nx;
  logic [9:0]       x_q, x_nx, y_q, y_nx;
  logic [5:0]       fcnt_q, fcnt_nx, alive_q, alive_nx;
  logic             cleared_q, cleared_nx, landed_q, landed_nx;
  logic             frame_d;

  logic [3:0]  leftcol, rightcol;
  logic [2:0]  bottomrow;
  logic        any_alive;
  logic        tick, step_due, drop, landing, hit_ok;
  logic [5:0]  hit_idx;
  logic [10:0] left_edge, right_edge, bottom_edge;
  logic [9:0]  x_step, y_drop;

  fleet_extent u_extent (
    .invaders  (mask_q),
    .leftcol   (leftcol),
    .rightcol  (rightcol),
    .bottomrow (bottomrow),
    .any_alive (any_alive)
  );

  assign tick     = frame & ~frame_d;
  assign step_due = ({1'b0, fcnt_q} + 7'd1) >= {1'b0, alive_q};

  // Edges and bottom are widened to 11 bits so the bound tests cannot wrap.
  assign left_edge   = 11'(x_q) + 11'(32'(leftcol) * OFFSET_H);
  assign right_edge  = 11'(x_q) + 11'(32'(rightcol) * OFFSET_H) + 11'(INV_W - 1);
  assign y_drop      = y_q + 10'(STEP_Y);
  assign bottom_edge = 11'(y_drop) + 11'(32'(bottomrow) * OFFSET_V) + 11'(INV_H);
  assign landing     = bottom_edge >= 11'(Y_LIMIT);
  assign drop        = (dir_q == DIR_RIGHT) ? ((right_edge + 11'(STEP_X)) > 11'(X_MAX))
                                            : (left_edge < 11'(X_MIN + STEP_X));
  assign x_step      = (dir_q == DIR_RIGHT) ? (x_q + 10'(STEP_X)) : (x_q - 10'(STEP_X));

  assign hit_idx = 6'((32'(hit_row) * INVADERS_H) + 32'(hit_col));
  assign hit_ok  = (state_q == FLEET_RUN) && hit && (hit_row < 3'(INVADERS_V))
                && (hit_col < 4'(INVADERS_H)) && mask_q[hit_idx];

  always_comb begin
    state_nx   = state_q;
    dir_nx     = dir_q;
    mask_nx    = mask_q;
    x_nx       = x_q;
    y_nx       = y_q;
    fcnt_nx    = fcnt_q;
    alive_nx   = alive_q;
    cleared_nx = cleared_q;
    landed_nx  = landed_q;
    if (start) begin
      state_nx   = FLEET_RUN;
      dir_nx     = DIR_RIGHT;
      mask_nx    = '1;
      x_nx       = 10'(START_X);
      y_nx       = 10'(START_Y);
      fcnt_nx    = '0;
      alive_nx   = 6'(N_INV);
      cleared_nx = 1'b0;
      landed_nx  = 1'b0;
    end else begin
      case (state_q)
        FLEET_RUN: begin
          if (!any_alive) begin
            cleared_nx = 1'b1;
            state_nx   = FLEET_CLEARED;
          end else begin
            // Motion uses the pre-hit mask; a same-cycle hit still applies below.
            if (tick) begin
              if (step_due) begin
                fcnt_nx = '0;
                if (drop) begin
                  y_nx   = y_drop;
                  dir_nx = (dir_q == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
                  if (landing) begin
                    landed_nx = 1'b1;
                    state_nx  = FLEET_LANDED;
                  end
                end else begin
                  x_nx = x_step;
                end
              end else begin
                fcnt_nx = fcnt_q + 6'd1;
              end
            end
            if (hit_ok) begin
              mask_nx[hit_idx] = 1'b0;
              alive_nx         = alive_q - 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FLEET_IDLE;
      dir_q     <= DIR_RIGHT;
      mask_q    <= '1;
      x_q       <= 10'(START_X);
      y_q       <= 10'(START_Y);
      fcnt_q    <= '0;
      alive_q   <= 6'(N_INV);
      cleared_q <= 1'b0;
      landed_q  <= 1'b0;
      frame_d   <= 1'b0;
    end else begin
      state_q   <= state_nx;
      dir_q     <= dir_nx;
      mask_q    <= mask_nx;
      x_q       <= x_nx;
      y_q       <= y_nx;
      fcnt_q    <= fcnt_nx;
      alive_q   <= alive_nx;
      cleared_q <= cleared_nx;
      landed_q  <= landed_nx;
      frame_d   <= frame;
    end
  end

  assign invaders    = mask_q;
  assign invaders_x  = x_q;
  assign invaders_y  = y_q;
  assign alive_count = alive_q;
  assign cleared     = cleared_q;
  assign landed      = landed_q;

endmodule

// File: tb/tb_invader_fleet.sv
// Scoreboarded bench for invader_fleet: a behavioural fleet model pushes the
// expected outputs each cycle, directed scenarios add fixed expectations.
module tb_invader_fleet;

  logic        clk = 1'b0;
  logic        rst, frame, start, hit;
  logic [2:0]  hit_row;
  logic [3:0]  hit_col;
  logic [54:0] invaders;
  logic [9:0]  invaders_x, invaders_y;
  logic [5:0]  alive_count;
  logic        cleared, landed;

  invader_fleet dut (
    .clk(clk), .rst(rst), .frame(frame), .start(start), .hit(hit),
    .hit_row(hit_row), .hit_col(hit_col), .invaders(invaders),
    .invaders_x(invaders_x), .invaders_y(invaders_y),
    .alive_count(alive_count), .cleared(cleared), .landed(landed)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit [5:0]    en;   // inv, x, y, cnt, clr, lnd
    logic [54:0] inv;
    int          x, y, cnt;
    bit          clr, lnd;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // ---------------- behavioural reference model ----------------
  bit [54:0] m_mask;
  int  m_x, m_y, m_fcnt, m_mode;   // mode: 0 idle, 1 run, 2 cleared, 3 landed
  bit  m_left, m_clr, m_lnd, m_fd;

  task automatic m_reload();
    m_mask = '1; m_x = 80; m_y = 64; m_fcnt = 0;
    m_left = 0; m_clr = 0; m_lnd = 0;
  endtask

  task automatic m_step(input bit [54:0] pre);
    int lc, rc, br;
    lc = 99; rc = -1; br = -1;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 11; c++)
        if (pre[r*11+c]) begin
          if (c < lc) lc = c;
          if (c > rc) rc = c;
          if (r > br) br = r;
        end
    if (!m_left ? (m_x + rc*32 + 23 + 4 > 631) : (m_x + lc*32 < 12)) begin
      m_y = m_y + 16;
      m_left = !m_left;
      if (m_y + br*32 + 16 >= 400) begin
        m_lnd = 1; m_mode = 3;
      end
    end else begin
      m_x = m_left ? m_x - 4 : m_x + 4;
    end
  endtask

  always @(posedge clk) begin : model
    bit [54:0] pre;
    exp_t e;
    int idx;
    if (rst) begin
      m_reload(); m_mode = 0; m_fd = 0;
    end else begin
      if (start) begin
        m_reload(); m_mode = 1;
      end else if (m_mode == 1) begin
        pre = m_mask;
        if ($countones(pre) == 0) begin
          m_clr = 1; m_mode = 2;
        end else begin
          if (frame && !m_fd) begin
            if (m_fcnt + 1 >= $countones(pre)) begin
              m_fcnt = 0;
              m_step(pre);
            end else begin
              m_fcnt++;
            end
          end
          idx = int'(hit_row) * 11 + int'(hit_col);
          if (hit && hit_row < 5 && hit_col < 11 && pre[idx]) m_mask[idx] = 0;
        end
      end
      m_fd = frame;
    end
    e.name = "model"; e.en = 6'h3F; e.inv = m_mask; e.x = m_x; e.y = m_y;
    e.cnt = $countones(m_mask); e.clr = m_clr; e.lnd = m_lnd;
    sb.push_back(e);
  end

  // ---------------- monitor ----------------
  task automatic cmp(input string nm, input string fld, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s.%s: got %0h, expected %0h (t=%0t)", nm, fld, act, want, $time);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.en[0]) cmp(e.name, "invaders", 64'(invaders), 64'(e.inv));
      if (e.en[1]) cmp(e.name, "x", 64'(invaders_x), 64'(e.x));
      if (e.en[2]) cmp(e.name, "y", 64'(invaders_y), 64'(e.y));
      if (e.en[3]) cmp(e.name, "alive_count", 64'(alive_count), 64'(e.cnt));
      if (e.en[4]) cmp(e.name, "cleared", 64'(cleared), 64'(e.clr));
      if (e.en[5]) cmp(e.name, "landed", 64'(landed), 64'(e.lnd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic want(input string nm, input bit [5:0] en, input logic [54:0] inv,
                      input int x, input int y, input int cnt, input bit clr, input bit lnd);
    exp_t e;
    e.name = nm; e.en = en; e.inv = inv; e.x = x; e.y = y; e.cnt = cnt; e.clr = clr; e.lnd = lnd;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic tick(input int hold);
    frame = 1; repeat (hold) cyc(); frame = 0; cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1);
  endtask

  task automatic do_hit(input int r, input int c);
    hit = 1; hit_row = 3'(r); hit_col = 4'(c); cyc(); hit = 0;
  endtask

  task automatic pulse_start();
    start = 1; cyc(); start = 0;
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin : driver
    logic [54:0] ones, m;
    int t;
    ones = '1;
    rst = 1; frame = 0; start = 0; hit = 0; hit_row = 0; hit_col = 0;
    repeat (2) cyc();
    want("reset", 6'h3F, ones, 80, 64, 55, 0, 0);
    rst = 0;

    // march timing: frame held 5 cycles is one tick; step on the 55th tick
    pulse_start();
    tick(5);
    ticks(53);
    want("tick54", 6'h06, '0, 80, 64, 0, 0, 0);
    ticks(1);
    want("tick55", 6'h06, '0, 84, 64, 0, 0, 0);

    // hits: kill, repeat kill, out-of-range rows/cols
    do_hit(0, 0);
    m = ones; m[0] = 1'b0;
    want("hit00", 6'h09, m, 0, 0, 54, 0, 0);
    do_hit(0, 0);
    want("hit00_again", 6'h08, '0, 0, 0, 54, 0, 0);
    do_hit(5, 0);
    want("hit_row5", 6'h09, m, 0, 0, 54, 0, 0);
    do_hit(0, 11);
    want("hit_col11", 6'h09, m, 0, 0, 54, 0, 0);

    // full fleet reaches the right edge: last move to 288, then drop
    pulse_start();
    ticks(53*55 - 1);
    want("pre_drop", 6'h06, '0, 288, 64, 0, 0, 0);
    ticks(1);
    want("drop", 6'h06, '0, 288, 80, 0, 0, 0);
    ticks(55);
    want("after_drop", 6'h06, '0, 284, 80, 0, 0, 0);

    // column 10 dead: right edge 32px narrower, drop at 320
    pulse_start();
    for (int r = 0; r < 5; r++) do_hit(r, 10);
    want("col10_dead", 6'h08, '0, 0, 0, 50, 0, 0);
    ticks(61*50 - 1);
    want("col10_pre_drop", 6'h06, '0, 320, 64, 0, 0, 0);
    ticks(1);
    want("col10_drop", 6'h06, '0, 320, 80, 0, 0, 0);

    // clear the fleet
    pulse_start();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 11; c++) do_hit(r, c);
    cyc();
    want("cleared", 6'h39, '0, 0, 0, 0, 1, 0);
    ticks(200);
    want("frozen", 6'h16, '0, 80, 64, 0, 1, 0);
    pulse_start();
    want("restart", 6'h3F, ones, 80, 64, 55, 0, 0);

    // landing with a single survivor at row 4 col 0 (period 1 tick)
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 11; c++)
        if (!(r == 4 && c == 0)) do_hit(r, c);
    t = 0;
    while (!m_lnd && t < 5000) begin
      tick(1);
      t++;
    end
    want("landed", 6'h24, '0, 0, 256, 0, 0, 1);
    do_hit(4, 0);
    want("hit_after_land", 6'h08, '0, 0, 0, 1, 0, 0);
    ticks(10);
    want("land_frozen", 6'h24, '0, 0, 256, 0, 0, 1);
    rst = 1; cyc(); rst = 0;
    want("rst_after_land", 6'h3F, ones, 80, 64, 55, 0, 0);

    // random frames, hits and occasional restarts
    pulse_start();
    for (int i = 0; i < 4000; i++) begin
      frame   = ($urandom_range(0, 2) == 0);
      hit     = ($urandom_range(0, 3) == 0);
      hit_row = 3'($urandom_range(0, 7));
      hit_col = 4'($urandom_range(0, 15));
      start   = ($urandom_range(0, 799) == 0);
      cyc();
    end
    frame = 0; hit = 0; start = 0;
    repeat (3) cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
